// File: rtl/pio_in_filter.sv
// Pad input conditioner for PIO: 2-flop synchronizer plus per-pin debounce filter
// with a shared tick prescaler. Optional glitch-status register under PIO_FILT_STAT_EN.
module pio_in_filter #(
    parameter int NPIN  = 12,
    parameter int CNT_W = 4,
    parameter int PRE_W = 8
) (
    input  logic             DSPCLK,
    input  logic             T_RST,
    input  logic [NPIN-1:0]  PAD_IN,
    input  logic [15:0]      DMD,
    input  logic             PFLT_we,
    input  logic             selPFLT,
`ifdef PIO_FILT_STAT_EN
    input  logic             PFSTAT_we,
    input  logic             selPFSTAT,
    output logic [15:0]      PFSTAT_DMD,
`endif
    output logic [NPIN-1:0]  PIO_IN,
    output logic [15:0]      PFLT_DMD
);

    logic [NPIN-1:0]  r_s1;
    logic [NPIN-1:0]  r_s2;
    logic [CNT_W-1:0] r_flt_n;
    logic [PRE_W-1:0] r_presc;
    logic [PRE_W-1:0] r_tc;
    logic             w_tick;
    logic             w_bypass;
    logic [CNT_W-1:0] w_flt_last;
    logic [NPIN-1:0]  w_pio;
    logic [7:0]       w_presc8;
    logic [3:0]       w_flt4;

    always_ff @(posedge DSPCLK or posedge T_RST) begin
        if (T_RST) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= PAD_IN;
            r_s2 <= r_s1;
        end
    end

    // Config write reloads the prescaler so the new tick period starts cleanly.
    always_ff @(posedge DSPCLK or posedge T_RST) begin
        if (T_RST) begin
            r_flt_n <= '0;
            r_presc <= '0;
            r_tc    <= '0;
        end else if (PFLT_we) begin
            r_flt_n <= DMD[CNT_W-1:0];
            r_presc <= DMD[8 +: PRE_W];
            r_tc    <= DMD[8 +: PRE_W];
        end else if (r_tc == '0) begin
            r_tc <= r_presc;
        end else begin
            r_tc <= r_tc - PRE_W'(1);
        end
    end

    assign w_tick     = (r_tc == '0) && !PFLT_we;
    assign w_bypass   = (r_flt_n == '0);
    assign w_flt_last = r_flt_n - CNT_W'(1);

`ifdef PIO_FILT_STAT_EN
    logic [NPIN-1:0] w_glitch;
    logic [NPIN-1:0] w_clr_mask;
    logic [11:0]     w_glitch12;

    assign w_clr_mask = NPIN'({DMD[15:12], DMD[7:0]});
    assign w_glitch12 = 12'(w_glitch);
    assign PFSTAT_DMD = selPFSTAT ? {w_glitch12[11:8], 4'b0, w_glitch12[7:0]} : 16'h0000;
`endif

    generate
        for (genvar gi = 0; gi < NPIN; gi++) begin : g_pin
            logic             r_pio;
            logic [CNT_W-1:0] r_cnt;

            // A tick that finds the input back at the output level discards the partial count.
            always_ff @(posedge DSPCLK or posedge T_RST) begin
                if (T_RST) begin
                    r_pio <= 1'b0;
                    r_cnt <= '0;
                end else if (PFLT_we) begin
                    r_cnt <= '0;
                end else if (w_bypass) begin
                    r_pio <= r_s2[gi];
                    r_cnt <= '0;
                end else if (w_tick) begin
                    if (r_s2[gi] == r_pio) begin
                        r_cnt <= '0;
                    end else if (r_cnt == w_flt_last) begin
                        r_pio <= r_s2[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_pio[gi] = r_pio;

`ifdef PIO_FILT_STAT_EN
            logic r_glitch;
            logic w_set;

            assign w_set = w_tick && !w_bypass && (r_cnt != '0) && (r_s2[gi] == r_pio);

            always_ff @(posedge DSPCLK or posedge T_RST) begin
                if (T_RST) begin
                    r_glitch <= 1'b0;
                end else if (w_set) begin
                    r_glitch <= 1'b1;
                end else if (PFSTAT_we && w_clr_mask[gi]) begin
                    r_glitch <= 1'b0;
                end
            end

            assign w_glitch[gi] = r_glitch;
`endif
        end
    endgenerate

    assign PIO_IN   = w_pio;
    assign w_presc8 = 8'(r_presc);
    assign w_flt4   = 4'(r_flt_n);
    assign PFLT_DMD = selPFLT ? {w_presc8, 4'b0, w_flt4} : 16'h0000;

endmodule

// File: tb/tb_pio_in_filter.sv
// Directed bench for pio_in_filter: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT.
module tb_pio_in_filter;

    logic        DSPCLK = 1'b0;
    logic        T_RST;
    logic [11:0] PAD_IN;
    logic [15:0] DMD;
    logic        PFLT_we;
    logic        selPFLT;
    logic        PFSTAT_we;
    logic        selPFSTAT;
    logic [15:0] PFSTAT_DMD;
    logic [11:0] PIO_IN;
    logic [15:0] PFLT_DMD;

    always #5 DSPCLK = ~DSPCLK;

    pio_in_filter dut (
        .DSPCLK     (DSPCLK),
        .T_RST      (T_RST),
        .PAD_IN     (PAD_IN),
        .DMD        (DMD),
        .PFLT_we    (PFLT_we),
        .selPFLT    (selPFLT),
`ifdef PIO_FILT_STAT_EN
        .PFSTAT_we  (PFSTAT_we),
        .selPFSTAT  (selPFSTAT),
        .PFSTAT_DMD (PFSTAT_DMD),
`endif
        .PIO_IN     (PIO_IN),
        .PFLT_DMD   (PFLT_DMD)
    );

`ifndef PIO_FILT_STAT_EN
    assign PFSTAT_DMD = 16'h0000;
`endif

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step(input int n);
        repeat (n) @(posedge DSPCLK);
        #1;
    endtask

    task automatic expect_val(input string name, input int sig, input logic [15:0] exp);
        chk_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic write_pflt(input logic [15:0] data);
        DMD     = data;
        PFLT_we = 1'b1;
        step(1);
        PFLT_we = 1'b0;
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    always @(negedge DSPCLK) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [15:0] act;
            c = q.pop_front();
            case (c.sig)
                0:       act = {4'h0, PIO_IN};
                1:       act = PFLT_DMD;
                default: act = PFSTAT_DMD;
            endcase
            n_checks++;
            if (act === c.exp) begin
                n_pass++;
                $display("ok   %s got %h", c.name, act);
            end else begin
                $display("FAIL %s got %h want %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        T_RST     = 1'b1;
        PAD_IN    = 12'hFFF;
        DMD       = 16'h0000;
        PFLT_we   = 1'b0;
        selPFLT   = 1'b1;
        PFSTAT_we = 1'b0;
        selPFSTAT = 1'b1;

        // Reset state, then bypass latency of 3 edges after release
        step(2);
        expect_val("rst_pio", 0, 16'h0000);
        expect_val("rst_pflt", 1, 16'h0000);
        step(1);
        T_RST = 1'b0;
        step(1); expect_val("byp_e1", 0, 16'h0000);
        step(1); expect_val("byp_e2", 0, 16'h0000);
        step(1); expect_val("byp_e3", 0, 16'h0FFF);

        // Readback and hold of PIO_IN across writes
        write_pflt(16'h4A07);
        expect_val("rb_4a07", 1, 16'h4A07);
        expect_val("hold_on_wr", 0, 16'h0FFF);
        step(1);
        selPFLT = 1'b0;
        expect_val("rb_nosel", 1, 16'h0000);
        step(1);
        selPFLT = 1'b1;
        write_pflt(16'hFFFF);
        expect_val("rb_ffff", 1, 16'hFF0F);

        PAD_IN = 12'h000;
        write_pflt(16'h0000);
        step(3);
        expect_val("byp_clear", 0, 16'h0000);

        // Glitch rejection: FLT_N=3, PRESC=0, pin 0 high for 2 cycles
        write_pflt(16'h0003);
        PAD_IN[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 2) PAD_IN[0] = 1'b0;
            expect_val($sformatf("glitch_e%0d", k), 0, 16'h0000);
        end
`ifdef PIO_FILT_STAT_EN
        expect_val("glitch_flag", 2, 16'h0001);
        step(1);
        DMD       = 16'h0001;
        PFSTAT_we = 1'b1;
        step(1);
        PFSTAT_we = 1'b0;
        expect_val("glitch_clr", 2, 16'h0000);
`endif

        // Acceptance: pin 5 rises and falls 5 edges after the pad changes
        PAD_IN[5] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            expect_val($sformatf("rise_e%0d", k), 0, (k >= 5) ? 16'h0020 : 16'h0000);
        end
        PAD_IN[5] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            expect_val($sformatf("fall_e%0d", k), 0, (k >= 5) ? 16'h0000 : 16'h0020);
        end

        // Prescaler: FLT_N=2, PRESC=4, ticks 5 and 10 edges after the write
        write_pflt(16'h0402);
        PAD_IN[11] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            expect_val($sformatf("presc_e%0d", k), 0, (k >= 10) ? 16'h0800 : 16'h0000);
        end

        // Mid-count rewrite of FLT_N=4 restarts the count from zero
        write_pflt(16'h0004);
        PAD_IN[3] = 1'b1;
        step(4);
        expect_val("mid_cnt2", 0, 16'h0800);
        write_pflt(16'h0004);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            expect_val($sformatf("mid_e%0d", k), 0, (k == 4) ? 16'h0808 : 16'h0800);
        end

        // Asynchronous reset in the middle of a count
        PAD_IN[0] = 1'b1;
        step(3);
        T_RST = 1'b1;
        expect_val("rst_mid_pio", 0, 16'h0000);
        expect_val("rst_mid_pflt", 1, 16'h0000);
        step(1);
        T_RST = 1'b0;
        step(2);
        expect_val("post_rst_e2", 0, 16'h0000);
        step(1);
        expect_val("post_rst_e3", 0, 16'h0809);

        step(2);
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain got %0d want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
